// File: rtl/memory_compute_prog.sv
// memory_compute_prog: NUM_FN_CALLS parallel lanes, each resolving its operand
// by lookup in one of NUM_FUNCTIONS run-time programmable tables selected per
// request by fn_sel. Two-stage pipeline (table read, output register) with a
// valid/ready handshake on both sides and a per-lane valid mask carried along.
//
// Optional feature macro: MEMORY_COMPUTE_PROG_INIT_CLEAR_EN
//   defined   : after reset a CLEAR state zeroes all TABLE_DEPTH entries, one
//               per cycle, with busy high; then RUN.
//   undefined : no CLEAR state, busy tied low, RUN whenever rst is low, and
//               table contents survive reset.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   data_in         lane operands, lane 0 in LSBs
//   data_in_valid   per-lane request valid (all-zero is not a request)
//   fn_sel          function table for this request
//   data_in_ready   request accepted this cycle when any lane valid
//   data_out        lane results, lane 0 in LSBs
//   data_out_mask   accepted data_in_valid of the result
//   data_out_valid  result present
//   data_out_ready  consumer takes result
//   cfg_wr_en       table write request
//   cfg_addr        table write address {fn, index}
//   cfg_data        table write data
//   cfg_wr_ready    write taken this cycle
//   busy            table clear in progress
module memory_compute_prog #(
  parameter int unsigned NUM_FN_CALLS  = 4,
  parameter int unsigned FN_CALL_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_FUNCTIONS = 2,
  localparam int unsigned FSEL_W = (NUM_FUNCTIONS > 2) ? $clog2(NUM_FUNCTIONS) : 1,
  localparam int unsigned AW     = FSEL_W + FN_CALL_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_FN_CALLS*FN_CALL_WIDTH-1:0] data_in,
  input  logic [NUM_FN_CALLS-1:0]               data_in_valid,
  input  logic [FSEL_W-1:0]                     fn_sel,
  output logic                                  data_in_ready,
  output logic [NUM_FN_CALLS*DATA_WIDTH-1:0]    data_out,
  output logic [NUM_FN_CALLS-1:0]               data_out_mask,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  input  logic                                  cfg_wr_en,
  input  logic [AW-1:0]                         cfg_addr,
  input  logic [DATA_WIDTH-1:0]                 cfg_data,
  output logic                                  cfg_wr_ready,
  output logic                                  busy
);

  localparam int unsigned TABLE_DEPTH = NUM_FUNCTIONS * (2 ** FN_CALL_WIDTH);
  localparam int unsigned FW1         = FSEL_W + 1;

  // All lanes read the same contents, so one array with a read port per lane
  // is equivalent to per-lane copies that each receive every write.
  logic [DATA_WIDTH-1:0] table_mem [TABLE_DEPTH];

  logic                  run;
  logic                  clr_we;
  logic [AW-1:0]         clr_addr;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  cfg_take;
  logic                  cfg_fn_ok;
  logic                  fn_in_ok;
  logic                  out_en;
  logic                  accept;

  logic [AW-1:0]         rd_addr [NUM_FN_CALLS];
  logic [DATA_WIDTH-1:0] rd_data [NUM_FN_CALLS];

  logic                              s1_valid;
  logic [NUM_FN_CALLS-1:0]           s1_mask;
  logic                              s1_fn_ok;
  logic [NUM_FN_CALLS*DATA_WIDTH-1:0] lane_res;

`ifdef MEMORY_COMPUTE_PROG_INIT_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state: sweep every table address with zero, then run
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we      = 1'b1;
        clr_cnt_nxt = clr_cnt + AW'(1);
        if (clr_cnt == AW'(TABLE_DEPTH - 1)) begin
          state_nxt   = ST_RUN;
          clr_cnt_nxt = '0;
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign clr_addr = clr_cnt;
  assign busy     = (state == ST_CLEAR);
  // Gating with rst keeps a producer from seeing a handshake the reset discards
  assign run      = (state == ST_RUN) && !rst;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
  assign run      = !rst;
`endif

  // Handshake decisions; config writes win over requests
  assign cfg_fn_ok     = {1'b0, cfg_addr[AW-1 -: FSEL_W]} < FW1'(NUM_FUNCTIONS);
  assign fn_in_ok      = {1'b0, fn_sel} < FW1'(NUM_FUNCTIONS);
  assign cfg_take      = run && cfg_wr_en;
  assign cfg_wr_ready  = cfg_take;
  assign out_en        = !data_out_valid || data_out_ready;
  assign data_in_ready = run && !cfg_wr_en && (!s1_valid || out_en);
  assign accept        = data_in_ready && (|data_in_valid);

  // Single table write port shared by clear sweep and config writes
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cfg_addr;
    wr_data = cfg_data;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = '0;
    end else if (cfg_take && cfg_fn_ok) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) table_mem[wr_addr] <= wr_data;
  end

  // Lane read addresses; an out-of-range function reads entry 0 and is zeroed later
  always_comb begin
    for (int l = 0; l < int'(NUM_FN_CALLS); l++) begin
      rd_addr[l] = '0;
      if (fn_in_ok) rd_addr[l] = {fn_sel, data_in[l*FN_CALL_WIDTH +: FN_CALL_WIDTH]};
    end
  end

  // Stage 1 data: synchronous table read, held while stage 1 is stalled
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < int'(NUM_FN_CALLS); l++) rd_data[l] <= table_mem[rd_addr[l]];
    end
  end

  // Stage 1 control
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_mask  <= '0;
      s1_fn_ok <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_mask  <= data_in_valid;
      s1_fn_ok <= fn_in_ok;
    end else if (out_en) begin
      s1_valid <= 1'b0;
    end
  end

  // Masked lanes and invalid functions produce zero
  always_comb begin
    lane_res = '0;
    for (int l = 0; l < int'(NUM_FN_CALLS); l++) begin
      if (s1_mask[l] && s1_fn_ok) lane_res[l*DATA_WIDTH +: DATA_WIDTH] = rd_data[l];
    end
  end

  // Stage 2: output register, frozen while a result waits for the consumer
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out       <= '0;
      data_out_mask  <= '0;
      data_out_valid <= 1'b0;
    end else if (out_en) begin
      data_out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= lane_res;
        data_out_mask <= s1_mask;
      end
    end
  end

endmodule

// File: tb/tb_memory_compute_prog.sv
// Testbench for memory_compute_prog: directed vectors checked by hand-computed
// literals, plus a per-cycle compare against a table/queue model.
module tb_memory_compute_prog;

  localparam int NL    = 4;
  localparam int NF    = 2;
  localparam int DEPTH = 512;
`ifdef MEMORY_COMPUTE_PROG_INIT_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [3:0]  data_in_valid;
  logic [0:0]  fn_sel;
  logic        data_in_ready;
  logic [31:0] data_out;
  logic [3:0]  data_out_mask;
  logic        data_out_valid;
  logic        data_out_ready;
  logic        cfg_wr_en;
  logic [8:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        cfg_wr_ready;
  logic        busy;

  memory_compute_prog #(
    .NUM_FN_CALLS(4), .FN_CALL_WIDTH(8), .DATA_WIDTH(8), .NUM_FUNCTIONS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .data_in(data_in), .data_in_valid(data_in_valid), .fn_sel(fn_sel),
    .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_mask(data_out_mask),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_wr_ready(cfg_wr_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [31:0] d;
    logic [3:0]  m;
    int          due;
  } exp_t;

  logic [7:0]  mtab [DEPTH];
  exp_t        q [$];
  logic [31:0] out_log [$];
  exp_t        pe;
  bit          have_rst = 1'b0;
  int          last_rst = 0;
  logic        run_exp;

  initial for (int i = 0; i < DEPTH; i++) mtab[i] = 8'h00;

  function automatic logic [31:0] model_result(input logic [31:0] d, input logic [3:0] v, input logic f);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < NL; l++)
      if (v[l] && int'(f) < NF) r[l*8 +: 8] = mtab[int'(f) * 256 + int'(d[l*8 +: 8])];
    return r;
  endfunction

  always @(negedge clk) begin
    if (have_rst) begin
      run_exp = !rst && (!CLR_EN || (cyc - last_rst >= DEPTH));
      check("busy", busy, CLR_EN && (cyc - last_rst < DEPTH));
      check("cfg_wr_ready", cfg_wr_ready, cfg_wr_en && run_exp);
      check("data_in_ready", data_in_ready, run_exp && !cfg_wr_en && (q.size() < 2 || data_out_ready));
      if (data_out_valid) begin
        if (q.size() == 0) check("spurious_valid", data_out_valid, 0);
        else begin
          check("out_data", data_out, q[0].d);
          check("out_mask", data_out_mask, q[0].m);
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        check("late_valid", data_out_valid, 1);
      end
    end else begin
      run_exp = 1'b0;
    end
    // Effects of the upcoming rising edge
    if (rst) begin
      q.delete();
      last_rst = cyc + 1;
      have_rst = 1'b1;
      if (CLR_EN) for (int i = 0; i < DEPTH; i++) mtab[i] = 8'h00;
    end else begin
      if (data_out_valid && data_out_ready && q.size() != 0) begin
        out_log.push_back(data_out);
        void'(q.pop_front());
      end
      if (cfg_wr_en && run_exp) mtab[int'(cfg_addr)] = cfg_data;
      if (data_in_valid != 4'b0 && data_in_ready) begin
        pe.d   = model_result(data_in, data_in_valid, fn_sel[0]);
        pe.m   = data_in_valid;
        pe.due = cyc + 2;
        q.push_back(pe);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] d, input logic [3:0] v, input logic f);
    int n;
    n = 0;
    data_in = d; data_in_valid = v; fn_sel = f;
    @(negedge clk);
    while (!data_in_ready && n < 50) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("send_accept", data_in_ready, 1);
    @(posedge clk); #1;
    data_in_valid = '0;
  endtask

  task automatic cfg_write(input logic [8:0] a, input logic [7:0] dv);
    int n;
    n = 0;
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_data = dv;
    @(negedge clk);
    while (!cfg_wr_ready && n < 50) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("cfg_accept", cfg_wr_ready, 1);
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // Send one request with an idle consumer path and check exact 2-cycle latency
  task automatic req_check(input string name, input logic [31:0] d, input logic [3:0] v,
                           input logic f, input logic [31:0] ed, input logic [3:0] em);
    send(d, v, f);
    @(negedge clk);
    check({name, "_lat1"}, data_out_valid, 0);
    @(negedge clk);
    check({name, "_valid"}, data_out_valid, 1);
    check({name, "_data"}, data_out, ed);
    check({name, "_mask"}, data_out_mask, em);
    @(posedge clk); #1;
  endtask

  task automatic wait_log(input int want);
    int n;
    n = 0;
    while (out_log.size() < want && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] bp_d   [4];
  logic [31:0] bp_exp [4];
  logic [7:0]  xb;
  int n, idx, acc, base;
  bit took;

  initial begin
    rst = 1'b1;
    data_in = '0; data_in_valid = '0; fn_sel = '0; data_out_ready = 1'b1;
    cfg_wr_en = 1'b0; cfg_addr = '0; cfg_data = '0;
    bp_d[0] = 32'h11; bp_d[1] = 32'h22; bp_d[2] = 32'h33; bp_d[3] = 32'h44;
    bp_exp[0] = 32'h01; bp_exp[1] = 32'h04; bp_exp[2] = 32'h09; bp_exp[3] = 32'h10;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset state and table clear
    if (CLR_EN) begin
      n = 0;
      @(negedge clk);
      check("rst_out_valid", data_out_valid, 0);
      check("rst_in_ready", data_in_ready, 0);
      while (busy && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("clear_cycles", n, 512);
      check("ready_after_clear", data_in_ready, 1);
      @(posedge clk); #1;
    end else begin
      @(negedge clk);
      check("rst_out_valid", data_out_valid, 0);
      check("busy_tied_low", busy, 0);
      check("ready_after_rst", data_in_ready, 1);
      @(posedge clk); #1;
      for (int a = 0; a < DEPTH; a++) cfg_write(9'(a), 8'h00);
    end

    req_check("zero_tbl", 32'h12233445, 4'hF, 1'b0, 32'h00000000, 4'hF);

    // fn0 = nibble product, fn1 = nibble sum
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      cfg_write({1'b0, xb}, 8'(xb[7:4]) * 8'(xb[3:0]));
    end
    for (int x = 0; x < 256; x++) begin
      xb = 8'(x);
      cfg_write({1'b1, xb}, 8'(xb[7:4]) + 8'(xb[3:0]));
    end

    req_check("fn0_mul", 32'h12233445, 4'hF, 1'b0, 32'h02060C14, 4'hF);
    req_check("fn1_add_masked", 32'h12233445, 4'b0101, 1'b1, 32'h00050009, 4'b0101);

    // Backpressure: 5 stalled cycles, then release
    base = out_log.size();
    data_out_ready = 1'b0;
    idx = 0; acc = 0;
    data_in = bp_d[0]; data_in_valid = 4'b0001; fn_sel = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); took = data_in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++; idx++;
        if (idx < 4) data_in = bp_d[idx]; else data_in_valid = '0;
      end
    end
    check("bp_accepts_in_stall", acc, 2);
    data_out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 50) begin
      n++;
      @(negedge clk); took = data_in_ready;
      @(posedge clk); #1;
      if (took) begin
        idx++;
        if (idx < 4) data_in = bp_d[idx]; else data_in_valid = '0;
      end
    end
    data_in_valid = '0;
    check("bp_all_accepted", idx, 4);
    wait_log(base + 4);
    check("bp_delivered", out_log.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < out_log.size()) check("bp_order", out_log[base + i], bp_exp[i]);

    // Write then read-after-write; request presented during the write is held off
    base = out_log.size();
    cfg_wr_en = 1'b1; cfg_addr = 9'h045; cfg_data = 8'hAA;
    data_in = 32'h45; data_in_valid = 4'b0001; fn_sel = 1'b0;
    @(negedge clk);
    check("raw_ready_blocked", data_in_ready, 0);
    check("raw_wr_ready", cfg_wr_ready, 1);
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    @(negedge clk);
    check("raw_ready_next", data_in_ready, 1);
    @(posedge clk); #1;
    data_in_valid = '0;
    wait_log(base + 1);
    check("raw_count", out_log.size() - base, 1);
    if (out_log.size() > base) check("raw_result", out_log[base], 32'h000000AA);

    // Reset with two results in flight
    data_out_ready = 1'b0;
    send(32'h23, 4'b0001, 1'b0);
    send(32'h34, 4'b0001, 1'b0);
    base = out_log.size();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", data_out_valid, 0);
    check("mid_rst_data", data_out, 32'h0);
    check("mid_rst_mask", data_out_mask, 4'h0);
    if (CLR_EN) begin
      check("mid_rst_busy", busy, 1);
      check("mid_rst_ready", data_in_ready, 0);
    end
    @(posedge clk); #1;
    data_out_ready = 1'b1;
    if (CLR_EN) begin
      cfg_wr_en = 1'b1; cfg_addr = 9'h045; cfg_data = 8'h55;
      @(negedge clk);
      check("clear_wr_ignored", cfg_wr_ready, 0);
      @(posedge clk); #1;
      cfg_wr_en = 1'b0;
      n = 0;
      while (busy && n < 600) begin
        n++;
        @(posedge clk); #1;
      end
      check("reclear_done", busy, 0);
    end
    repeat (4) @(posedge clk);
    #1;
    check("no_stale", out_log.size() - base, 0);
    req_check("post_reset", 32'h45, 4'b0001, 1'b0, CLR_EN ? 32'h0 : 32'hAA, 4'b0001);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
